// File: rtl/uart_pkg.sv
// Shared UART definitions, used by the transmitter and the future receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int UART_CLKS_PER_BIT_115200 = 434;
    localparam int UART_BITS_N              = 8;

endpackage

// File: rtl/uart_tx_core.sv
// 8N1-style frame serialiser. Pulls one byte per frame from an external
// source through a single-cycle load/byte_in/take handshake.
//
// state | meaning
// IDLE  | line high, waiting for a byte to be available
// START | driving the start bit (0)
// DATA  | shifting data bits out, LSB first
// STOP  | driving the stop bit (1); chains straight into START if more data
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_115200,
    parameter int BITS_N       = UART_BITS_N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [BITS_N-1:0] byte_in_i,
    output logic              take_o,
    output logic              tx_o,
    output logic              active_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (BITS_N > 1) ? $clog2(BITS_N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BITS_N - 1);

    tx_state_t         state_q, state_d;
    logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [BITS_N-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              bit_done;

    assign bit_done = (clk_cnt_q == CNT_LAST);
    assign tx_o     = tx_q;
    assign active_o = (state_q != IDLE);

    // Register FSM state, bit timing counters, shift register and line level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    // Next-state logic; the line level is registered, so each transition
    // sets the value the line takes on the same edge.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = bit_done ? '0 : clk_cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        take_o    = 1'b0;
        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (load_i) begin
                    take_o  = 1'b1;
                    shift_d = byte_in_i;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    tx_d      = shift_q[0];
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == IDX_LAST) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (load_i) begin
                        take_o  = 1'b1;
                        shift_d = byte_in_i;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: valid/ready byte intake into a circular FIFO,
// drained back-to-back by the frame serialiser.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_115200,
    parameter int BITS_N       = UART_BITS_N,
    parameter int DEPTH        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BITS_N-1:0]     data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  uart_out,
    output logic                  busy,
    output logic [$clog2(DEPTH):0] fill_level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [BITS_N-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full, empty, push, pop;
    logic              core_active;

    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign data_ready = rst && !full;
    assign push       = data_valid && data_ready;
    assign fill_level = count_q;
    assign busy       = !empty || core_active;

    // Serialiser only sees the FIFO head when the FIFO was non-empty before
    // the edge, so a byte written this edge cannot be popped this edge.
    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .BITS_N      (BITS_N)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load_i   (!empty),
        .byte_in_i(mem_q[rd_ptr_q]),
        .take_o   (pop),
        .tx_o     (uart_out),
        .active_o (core_active)
    );

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Register FIFO pointers and count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: frame-level reference model plus directed
// hand-computed frames and a second instance with a 7-bit data width.
module tb_uart_tx_buffered;

    localparam int C     = 4;
    localparam int N     = 8;
    localparam int D     = 16;
    localparam int FRAME = (N + 2) * C;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready, uart_out, busy;
    logic [4:0] fill_level;

    logic [6:0] d7;
    logic       v7, r7, u7, b7;
    logic [2:0] f7;

    int checks   = 0;
    int failures = 0;

    uart_tx_buffered #(.CLKS_PER_BIT(C), .BITS_N(N), .DEPTH(D)) u_dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .uart_out(uart_out), .busy(busy),
        .fill_level(fill_level)
    );

    uart_tx_buffered #(.CLKS_PER_BIT(3), .BITS_N(7), .DEPTH(4)) u_dut7 (
        .clk(clk), .rst(rst), .data_in(d7), .data_valid(v7),
        .data_ready(r7), .uart_out(u7), .busy(b7), .fill_level(f7)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model: byte queue + frame timeline ----------
    logic [7:0] mq[$];
    bit         m_in_frame = 1'b0;
    int         m_off      = 0;
    logic [7:0] m_cur      = '0;
    bit         m_ok       = 1'b0;
    bit         m_push;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                mq.delete();
                m_in_frame = 1'b0;
                m_off      = 0;
                m_ok       = 1'b1;
            end else begin
                m_push = data_valid && (mq.size() < D);
                if (m_in_frame && m_off < FRAME - 1) begin
                    m_off++;
                end else if (mq.size() > 0) begin
                    m_cur      = mq.pop_front();
                    m_in_frame = 1'b1;
                    m_off      = 0;
                end else begin
                    m_in_frame = 1'b0;
                end
                if (m_push) mq.push_back(data_in);
            end
        end
    end

    function automatic logic exp_line();
        int k;
        if (!m_in_frame) return 1'b1;
        k = m_off / C;
        if (k == 0) return 1'b0;
        if (k <= N) return m_cur[k-1];
        return 1'b1;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (m_ok) begin
                check("uart_out", 64'(uart_out), 64'(exp_line()));
                check("busy", 64'(busy), 64'(m_in_frame || (mq.size() != 0)));
                check("fill_level", 64'(fill_level), 64'(mq.size()));
                check("data_ready", 64'(data_ready), 64'(rst && (mq.size() < D)));
            end
        end
    end

    // ---------------- line recorder for directed frame checks ---------------
    bit   cap_en = 1'b0;
    logic cap_tx[$];
    logic cap_busy[$];

    initial begin
        forever begin
            @(negedge clk);
            if (cap_en) begin
                cap_tx.push_back(uart_out);
                cap_busy.push_back(busy);
            end
        end
    end

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 64'(busy), 64'd0);
        tick();
    endtask

    task automatic send_one_captured(input logic [7:0] b);
        cap_tx.delete();
        cap_busy.delete();
        cap_en     = 1'b1;
        data_valid = 1'b1;
        data_in    = b;
        tick();
        data_valid = 1'b0;
        repeat (50) tick();
        cap_en = 1'b0;
    endtask

    // lit is {stop, data[7:0], start}; each bit occupies C samples.
    task automatic check_capture(input string nm, input logic [9:0] lit, input int exp_z);
        int          z;
        logic [39:0] got, want;
        z = -1;
        for (int i = 0; i < cap_tx.size(); i++) begin
            if (cap_tx[i] == 1'b0) begin
                z = i;
                break;
            end
        end
        check({nm, "_latency"}, 64'(z), 64'(exp_z));
        if (z < 0 || cap_tx.size() < z + 41) begin
            check({nm, "_length"}, 64'(cap_tx.size()), 64'(z + 41));
            return;
        end
        for (int i = 0; i < 40; i++) begin
            got[i]  = cap_tx[z+i];
            want[i] = lit[i/4];
        end
        check({nm, "_bits"}, 64'(got), 64'(want));
        check({nm, "_busy_last"}, 64'(cap_busy[z+39]), 64'd1);
        check({nm, "_busy_fall"}, 64'(cap_busy[z+40]), 64'd0);
    endtask

    logic [7:0] json_s [7] = '{8'h7B, 8'h22, 8'h54, 8'h22, 8'h3A, 8'h31, 8'h7D};
    logic       s7 [29];
    logic       bb7 [29];

    initial begin
        int          acc, n, z, run;
        logic [7:0]  dec;
        logic [8:0]  lit9;
        logic [26:0] got7, want7;

        rst = 1'b0; data_valid = 1'b0; data_in = '0; v7 = 1'b0; d7 = '0;

        // reset
        repeat (3) tick();
        check("rst_uart_out", 64'(uart_out), 64'd1);
        check("rst_ready", 64'(data_ready), 64'd0);
        check("rst_fill", 64'(fill_level), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b1;
        #1;
        check("ready_after_release", 64'(data_ready), 64'd1);
        tick();

        // single byte 0x7B
        send_one_captured(8'h7B);
        check_capture("single_7b", 10'b1011110110, 2);
        wait_idle(100);

        // full FIFO with data_valid held high
        data_valid = 1'b1;
        data_in    = 8'($urandom);
        acc        = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!data_ready) break;
            acc++;
            tick();
            data_in = 8'($urandom);
        end
        check("full_accepted", 64'(acc), 64'd17);
        check("full_fill", 64'(fill_level), 64'd16);
        check("full_ready_low", 64'(data_ready), 64'd0);
        n = 0;
        while (!data_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("full_ready_back", 64'(data_ready), 64'd1);
        check("full_fill_after_pop", 64'(fill_level), 64'd15);
        tick();
        data_valid = 1'b0;
        wait_idle(1000);

        // contiguous JSON string
        cap_tx.delete();
        cap_busy.delete();
        cap_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            data_valid = 1'b1;
            data_in    = json_s[i];
            tick();
        end
        data_valid = 1'b0;
        wait_idle(400);
        tick();
        cap_en = 1'b0;
        z = -1;
        for (int i = 0; i < cap_tx.size(); i++) begin
            if (cap_tx[i] == 1'b0) begin
                z = i;
                break;
            end
        end
        check("json_latency", 64'(z), 64'd2);
        if (z >= 0 && cap_tx.size() >= z + 281) begin
            for (int f = 0; f < 7; f++) begin
                for (int b = 0; b < 8; b++) dec[b] = cap_tx[z + f*40 + (b+1)*4 + 2];
                check("json_start_edge", 64'(cap_tx[z + f*40]), 64'd0);
                check("json_stop", 64'(cap_tx[z + f*40 + 38]), 64'd1);
                check("json_byte", 64'(dec), 64'(json_s[f]));
            end
            run = 0;
            for (int i = z; i < cap_busy.size() && cap_busy[i]; i++) run++;
            check("json_busy_len", 64'(run), 64'd280);
        end else begin
            check("json_capture_len", 64'(cap_tx.size()), 64'(z + 281));
        end

        // reset during data bit 3 with 5 bytes queued
        for (int i = 0; i < 6; i++) begin
            data_valid = 1'b1;
            data_in    = 8'($urandom);
            tick();
        end
        data_valid = 1'b0;
        check("mid_queued", 64'(fill_level), 64'd5);
        repeat (13) tick();
        rst = 1'b0;
        tick();
        check("mid_rst_line", 64'(uart_out), 64'd1);
        check("mid_rst_fill", 64'(fill_level), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_ready", 64'(data_ready), 64'd0);
        rst = 1'b1;
        tick();
        send_one_captured(8'h0A);
        check_capture("after_rst_0a", 10'b1000010100, 2);
        wait_idle(100);

        // randomized traffic with occasional resets
        for (int i = 0; i < 2500; i++) begin
            data_valid = ($urandom_range(0, 3) != 0);
            data_in    = 8'($urandom);
            rst        = ($urandom_range(0, 599) != 0);
            tick();
        end
        rst        = 1'b1;
        data_valid = 1'b0;
        wait_idle(1000);

        // 7-bit variant, 0x55
        v7 = 1'b1;
        d7 = 7'h55;
        tick();
        v7 = 1'b0;
        for (int j = 0; j < 29; j++) begin
            @(negedge clk);
            s7[j]  = u7;
            bb7[j] = b7;
        end
        lit9 = 9'b110101010;
        for (int k = 0; k < 27; k++) begin
            got7[k]  = s7[1+k];
            want7[k] = lit9[k/3];
        end
        check("v7_idle_before", 64'(s7[0]), 64'd1);
        check("v7_frame", 64'(got7), 64'(want7));
        check("v7_busy_last", 64'(bb7[27]), 64'd1);
        check("v7_busy_fall", 64'(bb7[28]), 64'd0);
        check("v7_line_idle", 64'(s7[28]), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered UART transmitter that sits directly downstream of the JSON command sender in the motor-control path. It accepts bytes over a valid/ready handshake into an internal FIFO and serialises them as 8N1 frames on `uart_out` toward the motor driver board. The upstream sender can therefore push a whole JSON command string in a burst without tracking bit timing.

## Interface

**Parameters**

- `CLKS_PER_BIT`, default 434 (50 MHz / 115200): clock cycles per serial bit; must be ≥ 2.
- `BITS_N`, default 8: data bits per frame.
- `DEPTH`, default 16: FIFO entries; must be a power of 2.

**Ports**

- `clk`  input  1: system clock.
- `rst`  input  1: reset, synchronous, active-low; clock `clk`.
- `data_in`  input  BITS_N: byte to transmit.
- `data_valid`  input  1: `data_in` is valid.
- `data_ready`  output  1: FIFO can accept; equals `rst && !full`, combinational.
- `uart_out`  output  1: serial line, registered; idles high.
- `busy`  output  1: asserted while the FIFO is non-empty or a frame is in progress.
- `fill_level`  output  $clog2(DEPTH)+1: current FIFO occupancy.

## Operation

- **Handshake:** a byte is accepted on a rising edge where `data_valid && data_ready`. If `data_valid` is high while `data_ready` is low, nothing is written; upstream must hold its data. There is no overflow path.
- **FIFO:** circular buffer with read/write pointers of $clog2(DEPTH) bits that wrap naturally, plus a count register.
  - full = (count == DEPTH); empty = (count == 0).
  - A simultaneous push and pop leaves count unchanged.
  - A pop is only taken if the FIFO is non-empty before the edge. There is no bypass: a byte written this edge cannot be popped this edge.
- **Serialiser FSM:** states IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is not empty, pop into the shift register, drive `uart_out`=0 and go to START.
  - START: after CLKS_PER_BIT cycles, drive data bit 0 and go to DATA.
  - DATA: bits are sent LSB first, each held CLKS_PER_BIT cycles. After bit BITS_N-1 completes, drive 1 and go to STOP.
  - STOP: held CLKS_PER_BIT cycles. On its last cycle, if the FIFO is non-empty, pop and go directly to START with `uart_out`=0, giving no idle gap. Otherwise go to IDLE.
- **Counters:** `clk_cnt` counts 0..CLKS_PER_BIT-1 and wraps; `bit_idx` counts 0..BITS_N-1.
- **Reset (`rst`=0 sampled on an edge):** state→IDLE, `uart_out`→1, pointers, count and counters→0.
  - A frame in flight is truncated. This is accepted; the far end sees a framing error.
  - While `rst` is low, `data_ready`=0.

## Timing

- **Reset values:** `uart_out`=1, `busy`=0, `fill_level`=0, `data_ready`=0 while `rst` is low.
- **Latency:** byte accepted at edge E with FIFO empty and FSM idle → the pop occurs at edge E+1, so `uart_out` falls (start bit) on that same edge (E+1).
- **Frame length:** exactly (BITS_N+2)·CLKS_PER_BIT cycles. Consecutive frames are contiguous.
- `busy` falls on the edge where STOP completes with the FIFO empty.
- `fill_level` updates on the edge following each push/pop.

## Structure

- **Shared package `uart_pkg`:**
  - `tx_state_t` enum {IDLE, START, DATA, STOP}.
  - `UART_CLKS_PER_BIT_115200` = 434.
  - `UART_BITS_N` = 8.
  These are reused by the future UART receiver.
- **Sub-module `uart_tx_core`:** FSM plus shift register with a one-cycle `load`/`byte_in`/`take` interface. The FIFO lives in the top level.

## Test plan

- **Reset:** hold `rst`=0 for 3 cycles → `uart_out`=1, `data_ready`=0, `fill_level`=0, `busy`=0. After release, `data_ready`=1.
- **Single byte** (CLKS_PER_BIT=4): push 0x7B at edge E → `uart_out`=0 from E+1 for 4 cycles, then bits 1,1,0,1,1,1,1,0 each 4 cycles, then stop=1. `busy` falls 40 cycles after the start bit begins.
- **Full FIFO** (CLKS_PER_BIT=4, DEPTH=16): hold `data_valid` high → 17 bytes accepted (one popped at E+1), then `data_ready`=0 with `fill_level`=16. `data_ready` returns high the cycle after the next pop.
- **Contiguous string:** push `{"T":1}` (7 bytes) → 70·CLKS_PER_BIT contiguous cycles, no idle-high cycles between stop and next start. The decoded bytes match in order.
- **Reset mid-frame:** assert `rst` during data bit 3 with 5 bytes queued → `uart_out`=1 on the next edge, `fill_level`=0, `busy`=0. After release, push 0x0A → one clean frame.
- **Parameter variant:** BITS_N=7, push 0x55 → a 9-bit frame of (9·CLKS_PER_BIT) cycles, with data bits alternating 1,0 starting LSB.
